sweep_sequencer: RTL and testbench

- Master FSM on the driving side of the sweep-counter enable/done interface.
- Raises the horizontal sweep enable (HS) and the vertical sweep enable (VS) in turn, and waits for each counter's completion indication.
- Inserts a low gap between sweeps so each counter clears, and repeats the H/V pair a parameterised number of passes.
- Reports completion, and flags a fault if a counter never finishes (watchdog).

---
 rtl/sweep_if.sv | 25 ++
 rtl/sweep_sequencer.sv | 90 +++++++++
 tb/tb_sweep_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sweep_if.sv
// Enable/done handshake between the sweep sequencer (master) and the
// H/V sweep counters plus their controlling host (slave).
interface sweep_if;
  logic       start;
  logic       abort;
  logic       clr_err;
  logic       h_done;
  logic       v_done;
  logic       hs;
  logic       vs;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] state;

  modport master (
    input  start, abort, clr_err, h_done, v_done,
    output hs, vs, busy, done, err, state
  );

  modport slave (
    output start, abort, clr_err, h_done, v_done,
    input  hs, vs, busy, done, err, state
  );
endinterface

// File: rtl/sweep_sequencer.sv
// Drives HS then VS sweep enables with low gaps between them, repeats for
// NUM_PASSES pairs, and faults if a counter never reports done.
module sweep_sequencer #(
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 16384,
  parameter int NUM_PASSES = 1,
  parameter int TO_W       = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  sweep_if.master  bus
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int PW = $clog2(NUM_PASSES + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] H_SWEEP = 3'd1;
  localparam logic [2:0] H_GAP   = 3'd2;
  localparam logic [2:0] V_SWEEP = 3'd3;
  localparam logic [2:0] V_GAP   = 3'd4;
  localparam logic [2:0] FINISH  = 3'd5;
  localparam logic [2:0] FAULT   = 3'd6;

  logic [2:0]      state, state_nx;
  logic [TO_W-1:0] wd;
  logic [GW-1:0]   gap;
  logic [PW-1:0]   pass;
  logic            wd_exp, gap_end, last_pass;

  assign wd_exp    = (wd == TO_W'(TIMEOUT - 1));
  assign gap_end   = (gap == GW'(GAP_CYCLES - 1));
  assign last_pass = (pass == PW'(NUM_PASSES - 1));

  // abort is tested first in every active state so it beats done/timeout
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start && !bus.abort) state_nx = H_SWEEP;
      H_SWEEP: if (bus.abort)               state_nx = IDLE;
               else if (bus.h_done)         state_nx = H_GAP;
               else if (wd_exp)             state_nx = FAULT;
      H_GAP:   if (bus.abort)               state_nx = IDLE;
               else if (gap_end)            state_nx = V_SWEEP;
      V_SWEEP: if (bus.abort)               state_nx = IDLE;
               else if (bus.v_done)         state_nx = V_GAP;
               else if (wd_exp)             state_nx = FAULT;
      V_GAP:   if (bus.abort)               state_nx = IDLE;
               else if (gap_end)            state_nx = last_pass ? FINISH : H_SWEEP;
      FINISH:                               state_nx = IDLE;
      FAULT:   if (bus.clr_err)             state_nx = IDLE;
      default:                              state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wd    <= '0;
      gap   <= '0;
      pass  <= '0;
    end else begin
      state <= state_nx;

      // watchdog runs only while a sweep persists; any entry or gap clears it
      if ((state_nx == H_SWEEP || state_nx == V_SWEEP) && state_nx == state) begin
        if (wd != '1) wd <= wd + 1'b1;
      end else begin
        wd <= '0;
      end

      if ((state_nx == H_GAP || state_nx == V_GAP) && state_nx == state)
        gap <= gap + 1'b1;
      else
        gap <= '0;

      if (state == IDLE)
        pass <= '0;
      else if (state == V_GAP && state_nx == H_SWEEP)
        pass <= pass + 1'b1;
    end
  end

  // outputs are pure decodes of the state register
  assign bus.hs    = (state == H_SWEEP);
  assign bus.vs    = (state == V_SWEEP);
  assign bus.busy  = (state != IDLE) && (state != FAULT);
  assign bus.done  = (state == FINISH);
  assign bus.err   = (state == FAULT);
  assign bus.state = state;
endmodule

// File: tb/tb_sweep_sequencer.sv
// Directed bench: main instance (GAP=4, TIMEOUT=100, 2 passes) and a
// single-pass instance for the stale-done scenario.
`timescale 1ns/1ps
module tb_sweep_sequencer;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sweep_if bus1();
  sweep_if bus2();

  sweep_sequencer #(.GAP_CYCLES(4), .TIMEOUT(100), .NUM_PASSES(2), .TO_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.master));

  sweep_sequencer #(.GAP_CYCLES(4), .TIMEOUT(100), .NUM_PASSES(1), .TO_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // packed view {hs, vs, busy, done, err, state[2:0]}
  function automatic logic [7:0] exp_o(input bit hs, input bit vs, input bit busy,
                                       input bit dn, input bit er, input logic [2:0] st);
    return {hs, vs, busy, dn, er, st};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (hs vs busy done err state)", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic [7:0] exp);
    chk(tag, {bus1.hs, bus1.vs, bus1.busy, bus1.done, bus1.err, bus1.state}, exp);
  endtask

  task automatic chk2(input string tag, input logic [7:0] exp);
    chk(tag, {bus2.hs, bus2.vs, bus2.busy, bus2.done, bus2.err, bus2.state}, exp);
  endtask

  // done is raised during the last cycle so the enable is high exactly len cycles
  task automatic h_sweep(input int len);
    for (int i = 0; i < len; i++) begin
      chk1("h_sweep", exp_o(1, 0, 1, 0, 0, 3'd1));
      if (i == len - 1) bus1.h_done = 1'b1;
      tick;
      bus1.h_done = 1'b0;
    end
  endtask

  task automatic v_sweep(input int len);
    for (int i = 0; i < len; i++) begin
      chk1("v_sweep", exp_o(0, 1, 1, 0, 0, 3'd3));
      if (i == len - 1) bus1.v_done = 1'b1;
      tick;
      bus1.v_done = 1'b0;
    end
  endtask

  task automatic gap(input logic [2:0] st);
    for (int i = 0; i < 4; i++) begin
      chk1("gap", exp_o(0, 0, 1, 0, 0, st));
      tick;
    end
  endtask

  task automatic full_run(input bit back_to_back);
    bus1.start = 1'b1;
    tick;
    bus1.start = 1'b0;
    for (int p = 0; p < 2; p++) begin
      h_sweep(10);
      gap(3'd2);
      v_sweep(20);
      gap(3'd4);
    end
    chk1("finish", exp_o(0, 0, 1, 1, 0, 3'd5));
    if (back_to_back) bus1.start = 1'b1;
    tick;
    chk1("idle_after_finish", exp_o(0, 0, 0, 0, 0, 3'd0));
    if (back_to_back) begin
      tick;
      bus1.start = 1'b0;
      chk1("back_to_back_start", exp_o(1, 0, 1, 0, 0, 3'd1));
      bus1.abort = 1'b1;
      tick;
      bus1.abort = 1'b0;
      chk1("abort_b2b", exp_o(0, 0, 0, 0, 0, 3'd0));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    {bus1.start, bus1.abort, bus1.clr_err, bus1.h_done, bus1.v_done} = '0;
    {bus2.start, bus2.abort, bus2.clr_err, bus2.h_done, bus2.v_done} = '0;

    // reset state
    repeat (3) tick;
    chk1("reset1", exp_o(0, 0, 0, 0, 0, 3'd0));
    chk2("reset2", exp_o(0, 0, 0, 0, 0, 3'd0));
    rst_n = 1'b1;
    tick;
    chk1("idle_post_reset", exp_o(0, 0, 0, 0, 0, 3'd0));

    // nominal two-pass run, then back-to-back START after FINISH
    full_run(1'b0);
    full_run(1'b1);

    // watchdog: HS high exactly 100 cycles then FAULT
    bus1.start = 1'b1;
    tick;
    bus1.start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      chk1("wd_hs_high", exp_o(1, 0, 1, 0, 0, 3'd1));
      tick;
    end
    chk1("wd_fault", exp_o(0, 0, 0, 0, 1, 3'd6));
    bus1.start = 1'b1;
    bus1.abort = 1'b1;
    tick;
    bus1.start = 1'b0;
    bus1.abort = 1'b0;
    chk1("fault_ignores_start_abort", exp_o(0, 0, 0, 0, 1, 3'd6));
    bus1.clr_err = 1'b1;
    tick;
    bus1.clr_err = 1'b0;
    chk1("clr_err", exp_o(0, 0, 0, 0, 0, 3'd0));

    // done and timeout on the same edge: done wins
    bus1.start = 1'b1;
    tick;
    bus1.start = 1'b0;
    for (int i = 0; i < 99; i++) tick;
    chk1("sim_cycle99", exp_o(1, 0, 1, 0, 0, 3'd1));
    bus1.h_done = 1'b1;
    tick;
    bus1.h_done = 1'b0;
    chk1("sim_done_wins", exp_o(0, 0, 1, 0, 0, 3'd2));
    bus1.abort = 1'b1;
    tick;
    bus1.abort = 1'b0;
    chk1("abort_in_gap", exp_o(0, 0, 0, 0, 0, 3'd0));

    // abort beats done; abort with start in IDLE stays idle
    bus1.start = 1'b1;
    tick;
    bus1.start  = 1'b0;
    bus1.h_done = 1'b1;
    bus1.abort  = 1'b1;
    tick;
    bus1.h_done = 1'b0;
    bus1.abort  = 1'b0;
    chk1("abort_beats_done", exp_o(0, 0, 0, 0, 0, 3'd0));
    bus1.start = 1'b1;
    bus1.abort = 1'b1;
    tick;
    bus1.start = 1'b0;
    bus1.abort = 1'b0;
    chk1("start_abort_idle", exp_o(0, 0, 0, 0, 0, 3'd0));

    // abort during second V sweep, then a fresh run covers two full passes
    bus1.start = 1'b1;
    tick;
    bus1.start = 1'b0;
    h_sweep(10);
    gap(3'd2);
    v_sweep(20);
    gap(3'd4);
    h_sweep(10);
    gap(3'd2);
    for (int i = 0; i < 5; i++) begin
      chk1("v2_before_abort", exp_o(0, 1, 1, 0, 0, 3'd3));
      tick;
    end
    bus1.abort = 1'b1;
    tick;
    bus1.abort = 1'b0;
    chk1("abort_v2", exp_o(0, 0, 0, 0, 0, 3'd0));
    tick;
    chk1("abort_no_done", exp_o(0, 0, 0, 0, 0, 3'd0));
    full_run(1'b0);

    // stale done on single-pass instance
    bus2.h_done = 1'b1;
    bus2.v_done = 1'b1;
    bus2.start  = 1'b1;
    tick;
    bus2.start = 1'b0;
    chk2("stale_h_sweep", exp_o(1, 0, 1, 0, 0, 3'd1));
    tick;
    for (int i = 0; i < 4; i++) begin
      chk2("stale_h_gap", exp_o(0, 0, 1, 0, 0, 3'd2));
      tick;
    end
    chk2("stale_v_one_cycle", exp_o(0, 1, 1, 0, 0, 3'd3));
    tick;
    for (int i = 0; i < 4; i++) begin
      chk2("stale_v_gap", exp_o(0, 0, 1, 0, 0, 3'd4));
      tick;
    end
    chk2("stale_finish", exp_o(0, 0, 1, 1, 0, 3'd5));
    tick;
    chk2("stale_idle", exp_o(0, 0, 0, 0, 0, 3'd0));
    bus2.h_done = 1'b0;
    bus2.v_done = 1'b0;

    // asynchronous reset mid H sweep, between edges
    bus1.start = 1'b1;
    tick;
    bus1.start = 1'b0;
    tick;
    tick;
    chk1("pre_async_reset", exp_o(1, 0, 1, 0, 0, 3'd1));
    #2;
    rst_n = 1'b0;
    #1;
    chk1("async_reset_drop", exp_o(0, 0, 0, 0, 0, 3'd0));
    tick;
    rst_n = 1'b1;
    repeat (3) tick;
    chk1("idle_after_release", exp_o(0, 0, 0, 0, 0, 3'd0));
    bus1.start = 1'b1;
    tick;
    bus1.start = 1'b0;
    chk1("start_after_release", exp_o(1, 0, 1, 0, 0, 3'd1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
